mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 182 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply / multiply-accumulate / divide
// unit with HI/LO result registers. One iteration per clock, 32 iterations.
// Optional divider datapath (ops 100/101) compiled in when MDU_DIV_EN is defined.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] mcand;      // multiplicand magnitude, or divisor magnitude
  logic [31:0] acc;        // upper product half, or partial remainder
  logic [31:0] mq;         // multiplier / dividend shifting out, result shifting in
  logic        sgn_q;      // signed operation
  logic        madd_q;     // accumulate onto {hi,lo}
  logic        neg_res;    // product / quotient must be negated
`ifdef MDU_DIV_EN
  logic        div_q;
  logic        neg_rem;    // remainder takes the sign of the dividend
  logic [31:0] a_q;        // raw dividend, returned as remainder on divide by zero
  logic [32:0] shl, trial;
  logic [31:0] quo, rem;
`endif

  logic        legal, accept, wr_ok, last;
  logic        sgn;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum;
  logic [31:0] it_acc, it_mq;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  // Decode op legality, operand magnitudes and acceptance of a new start
  always_comb begin
`ifdef MDU_DIV_EN
    legal = (op[2:1] != 2'b11);
`else
    legal = ~op[2];
`endif
    sgn    = ~op[0];
    accept = start & legal & (state != RUN);
    wr_ok  = (state != RUN);
    last   = (state == RUN) && (cnt == 5'd31);
    a_mag  = (sgn & a[31]) ? (32'd0 - a) : a;
    b_mag  = (sgn & b[31]) ? (32'd0 - b) : b;
  end

  // One radix-2 iteration: shift-add multiply, or restoring shift-subtract divide
  always_comb begin
    sum    = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : 33'd0);
    it_acc = sum[32:1];
    it_mq  = {sum[0], mq[31:1]};
`ifdef MDU_DIV_EN
    shl   = {acc, mq[31]};
    trial = shl - {1'b0, mcand};
    if (div_q) begin
      if (!trial[32]) begin
        it_acc = trial[31:0];
        it_mq  = {mq[30:0], 1'b1};
      end else begin
        it_acc = shl[31:0];
        it_mq  = {mq[30:0], 1'b0};
      end
    end
`endif
  end

  // Final result from the last iteration: sign correction and accumulation
  always_comb begin
    prod = {it_acc, it_mq};
    if (neg_res) prod = 64'd0 - prod;
    if (madd_q)  prod = prod + {hi, lo};
    res_hi = prod[63:32];
    res_lo = prod[31:0];
`ifdef MDU_DIV_EN
    quo = neg_res ? (32'd0 - it_mq)  : it_mq;
    rem = neg_rem ? (32'd0 - it_acc) : it_acc;
    if (div_q) begin
      // a zero divisor magnitude means b was zero
      if (mcand == 32'd0) begin
        res_lo = '1;
        res_hi = a_q;
      end else begin
        res_lo = quo;
        res_hi = rem;
      end
    end
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == 5'd31) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = accept ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      sgn_q   <= 1'b0;
      madd_q  <= 1'b0;
      neg_res <= 1'b0;
`ifdef MDU_DIV_EN
      div_q   <= 1'b0;
      neg_rem <= 1'b0;
      a_q     <= '0;
`endif
    end else if (accept) begin
      cnt     <= '0;
      acc     <= '0;
      sgn_q   <= sgn;
      madd_q  <= ~op[2] & op[1];
      neg_res <= sgn & (a[31] ^ b[31]);
      mcand   <= a_mag;
      mq      <= b_mag;
`ifdef MDU_DIV_EN
      div_q   <= op[2];
      neg_rem <= sgn & a[31];
      a_q     <= a;
      if (op[2]) begin
        mcand <= b_mag;
        mq    <= a_mag;
      end
`endif
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      acc <= it_acc;
      mq  <= it_mq;
    end
  end

  // HI/LO: updated on completion, or by mthi/mtlo outside RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (last) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (wr_ok) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [2:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one operation; returns in the DONE cycle. Disturbs inputs mid-run
  // (new start, mthi/mtlo, operand changes) which must all be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic wr, input logic [31:0] wd,
                        input logic [31:0] e_hi, input logic [31:0] e_lo);
    int n;
    op = o; a = va; b = vb; start = 1'b1;
    mthi = wr; mtlo = wr; wdata = wd;
    if (wr) begin
      exp_hi = wd;
      exp_lo = wd;
    end
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
      if (n == 4) begin
        start = 1'b1; op = 3'b001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
      end
      if (n == 5) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = $urandom; b = $urandom;
      end
      if (n == 16) begin
        check({tag, "_hi_hold"}, hi, exp_hi);
        check({tag, "_lo_hold"}, lo, exp_lo);
        check({tag, "_done_run"}, {31'd0, done}, 32'd0);
      end
    end
    check({tag, "_cycles"}, n, 32'd32);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, e_hi);
    check({tag, "_lo"}, lo, e_lo);
    exp_hi = e_hi;
    exp_lo = e_lo;
  endtask

  task automatic to_idle(input string tag);
    tick();
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic ignored_op(input string tag, input logic [2:0] o);
    op = o; a = 32'd9; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, "_busy2"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst = 1'b0;
    tick();

    run_op("mult_m1x2", 3'b000, 32'hFFFFFFFF, 32'd2, 1'b0, '0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    // back-to-back: start accepted in the DONE cycle
    run_op("multu_m1x2", 3'b001, 32'hFFFFFFFF, 32'd2, 1'b0, '0, 32'h00000001, 32'hFFFFFFFE);
    to_idle("multu");
    run_op("mult_m3x5", 3'b000, 32'hFFFFFFFD, 32'd5, 1'b0, '0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("mult_min2", 3'b000, 32'h80000000, 32'h80000000, 1'b0, '0, 32'h40000000, 32'h00000000);
    to_idle("min2");

    // mthi / mtlo on separate edges, then carry-propagating maddu
    mthi = 1'b1; wdata = 32'd0; tick(); mthi = 1'b0;
    mtlo = 1'b1; wdata = 32'hFFFFFFFF; tick(); mtlo = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'hFFFFFFFF;
    check("mt_hi", hi, 32'd0);
    check("mt_lo", lo, 32'hFFFFFFFF);
    run_op("maddu_carry", 3'b011, 32'd1, 32'd1, 1'b0, '0, 32'h00000001, 32'h00000000);
    to_idle("maddu");
    run_op("madd_neg", 3'b010, 32'hFFFFFFFF, 32'd1, 1'b0, '0, 32'h00000000, 32'hFFFFFFFF);
    to_idle("madd");
    // mthi+mtlo on the same edge as an accepted madd
    run_op("madd_wr", 3'b010, 32'd2, 32'd3, 1'b1, 32'd5, 32'h00000005, 32'h0000000B);
    to_idle("madd_wr");

    ignored_op("illegal_110", 3'b110);
    ignored_op("illegal_111", 3'b111);

`ifdef MDU_DIV_EN
    run_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 1'b0, '0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_7_0", 3'b101, 32'd7, 32'd0, 1'b0, '0, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b0, '0, 32'h00000000, 32'h80000000);
    run_op("div_7_m2", 3'b100, 32'd7, 32'hFFFFFFFE, 1'b0, '0, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 1'b0, '0, 32'h00000002, 32'd14);
    run_op("div_m5_0", 3'b100, 32'hFFFFFFFB, 32'd0, 1'b0, '0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    to_idle("div");
`else
    ignored_op("nodiv_100", 3'b100);
    ignored_op("nodiv_101", 3'b101);
`endif

    // reset in the middle of an operation
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678; tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("pre_rst_hi", hi, 32'h12345678);
    op = 3'b001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    tick();
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    tick();
    run_op("mult_3x4", 3'b000, 32'd3, 32'd4, 1'b0, '0, 32'd0, 32'd12);
    to_idle("mult_3x4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
